// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, valid/ready handshake, flush.
// Optional divide-by-zero guard enabled by defining ID_EX_DIV_ZERO_GUARD_EN.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_alu_control,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_reg_write,
    input  logic [31:0] exmem_result,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_reg_write,
    input  logic [31:0] memwb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_control,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_div_zero
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned OW = 4;

    localparam logic [OW-1:0] OP_DIV     = OW'(4'b0011);
    localparam logic [OW-1:0] OP_DEFAULT = OW'(4'b1111);

    logic          capture;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;
    logic [DW-1:0] y_next;
    logic [OW-1:0] op_next;
    logic          div_zero_next;

    // A slot is free when empty or draining this edge.
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Operand forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded.
    always_comb begin
        fwd_rs = in_rs_data;
        fwd_rt = in_rt_data;
        if (in_rs != RW'(0) && exmem_reg_write && exmem_rd == in_rs) begin
            fwd_rs = exmem_result;
        end else if (in_rs != RW'(0) && memwb_reg_write && memwb_rd == in_rs) begin
            fwd_rs = memwb_data;
        end
        if (in_rt != RW'(0) && exmem_reg_write && exmem_rd == in_rt) begin
            fwd_rt = exmem_result;
        end else if (in_rt != RW'(0) && memwb_reg_write && memwb_rd == in_rt) begin
            fwd_rt = memwb_data;
        end
    end

    assign y_next = in_use_imm ? in_imm : fwd_rt;

    // Divide with a zero divisor is rewritten to the ALU default op.
    always_comb begin
        op_next       = in_alu_control;
        div_zero_next = 1'b0;
`ifdef ID_EX_DIV_ZERO_GUARD_EN
        if (in_alu_control == OP_DIV && y_next == DW'(0)) begin
            op_next       = OP_DEFAULT;
            div_zero_next = 1'b1;
        end
`endif
    end

    // Pipeline register: flush beats capture beats hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_alu_control <= OW'(0);
            out_x           <= DW'(0);
            out_y           <= DW'(0);
            out_rd          <= RW'(0);
            out_reg_write   <= 1'b0;
            out_div_zero    <= 1'b0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
        end else if (capture) begin
            out_valid       <= 1'b1;
            out_alu_control <= op_next;
            out_x           <= fwd_rs;
            out_y           <= y_next;
            out_rd          <= in_rd;
            out_reg_write   <= in_reg_write;
            out_div_zero    <= div_zero_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps plus random traffic against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_control;
    logic [31:0] in_rs_data, in_rt_data, in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        in_reg_write;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_reg_write;
    logic [31:0] memwb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_control;
    logic [31:0] out_x, out_y;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_div_zero;

    int errors = 0;
    int checks = 0;

    // Expected contents of the output register
    logic        m_valid;
    logic [3:0]  m_op;
    logic [31:0] m_x, m_y;
    logic [4:0]  m_rd;
    logic        m_rw;
    logic        m_dz;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_control(in_alu_control), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_control(out_alu_control), .out_x(out_x), .out_y(out_y),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_div_zero(out_div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] regval);
        if (idx == 0) return regval;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_data;
        return regval;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = 0; m_x = 0; m_y = 0; m_rd = 0; m_rw = 0; m_dz = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".reg_write"}, 32'(out_reg_write), 32'(m_valid ? m_rw : out_reg_write & m_rw));
        if (m_valid) begin
            chk({tag, ".op"}, 32'(out_alu_control), 32'(m_op));
            chk({tag, ".x"}, out_x, m_x);
            chk({tag, ".y"}, out_y, m_y);
            chk({tag, ".rd"}, 32'(out_rd), 32'(m_rd));
            chk({tag, ".div_zero"}, 32'(out_div_zero), 32'(m_dz));
        end
    endtask

    // Predict the next register contents from current inputs, clock once, compare.
    task automatic tick(input string tag);
        logic [31:0] y;
        logic        accept;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
        accept = in_valid && (!m_valid || out_ready);
        if (flush) begin
            m_valid = 0;
            m_rw    = 0;
        end else if (accept) begin
            y       = in_use_imm ? in_imm : fwd(in_rt, in_rt_data);
            m_valid = 1;
            m_x     = fwd(in_rs, in_rs_data);
            m_y     = y;
            m_rd    = in_rd;
            m_rw    = in_reg_write;
            m_op    = in_alu_control;
            m_dz    = 0;
`ifdef ID_EX_DIV_ZERO_GUARD_EN
            if (in_alu_control == 4'b0011 && y == 0) begin
                m_op = 4'b1111;
                m_dz = 1;
            end
`endif
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic quiet_inputs();
        in_valid = 0; in_alu_control = 0; in_rs_data = 0; in_rt_data = 0; in_imm = 0;
        in_use_imm = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_reg_write = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_data = 0; flush = 0; out_ready = 1;
    endtask

    // Small register range so forwarding hits are frequent.
    task automatic random_inputs();
        in_valid        = 1'($urandom_range(0, 3) != 0);
        in_alu_control  = ($urandom_range(0, 3) == 0) ? 4'b0011 : 4'($urandom);
        in_rs_data      = $urandom;
        in_rt_data      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        in_imm          = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        in_use_imm      = 1'($urandom);
        in_rs           = 5'($urandom_range(0, 3));
        in_rt           = 5'($urandom_range(0, 3));
        in_rd           = 5'($urandom);
        in_reg_write    = 1'($urandom);
        exmem_rd        = 5'($urandom_range(0, 3));
        exmem_reg_write = 1'($urandom);
        exmem_result    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        memwb_rd        = 5'($urandom_range(0, 3));
        memwb_reg_write = 1'($urandom);
        memwb_data      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        flush           = 1'($urandom_range(0, 15) == 0);
        out_ready       = 1'($urandom_range(0, 2) != 0);
    endtask

    initial begin
        quiet_inputs();
        model_reset();
        rst_n = 0;
        #12;
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.x", out_x, 32'd0);
        chk("reset.op", 32'(out_alu_control), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1;

        // Basic transfer
        in_valid = 1; in_alu_control = 4'b0000; in_rs_data = 5; in_rt_data = 7;
        in_rs = 1; in_rt = 2; in_rd = 9; in_reg_write = 1;
        tick("basic");
        chk("basic.x_lit", out_x, 32'd5);
        chk("basic.y_lit", out_y, 32'd7);

        // Forwarding priority
        in_rs = 3; in_rs_data = 32'h11;
        exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'hAA;
        memwb_rd = 3; memwb_reg_write = 1; memwb_data = 32'hBB;
        tick("fwd_exmem");
        chk("fwd_exmem.lit", out_x, 32'hAA);
        exmem_reg_write = 0;
        tick("fwd_memwb");
        chk("fwd_memwb.lit", out_x, 32'hBB);
        exmem_reg_write = 1; in_rs = 0; exmem_rd = 0; memwb_rd = 0;
        tick("fwd_r0");
        chk("fwd_r0.lit", out_x, 32'h11);
        quiet_inputs();

        // Backpressure: three stalled cycles offering new beats, then release
        in_valid = 1; in_rs_data = 32'h100; in_rd = 4; in_reg_write = 1;
        tick("bp_load");
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_rs_data = 32'h200 + 32'(i);
            tick("bp_hold");
            chk("bp_hold.x_lit", out_x, 32'h100);
        end
        out_ready = 1; in_rs_data = 32'h300;
        tick("bp_release");
        chk("bp_release.x_lit", out_x, 32'h300);
        in_valid = 0;
        tick("bp_drain");

        // Flush over a held beat with a simultaneous input
        in_valid = 1; in_rs_data = 32'h400; in_reg_write = 1;
        tick("fl_load");
        out_ready = 0; flush = 1; in_rs_data = 32'h500;
        tick("flush");
        chk("flush.reg_write_lit", 32'(out_reg_write), 32'd0);
        flush = 0; in_valid = 0; out_ready = 1;
        tick("fl_idle");

        // Divide guard
        in_valid = 1; in_alu_control = 4'b0011; in_rt = 5; in_rt_data = 0;
        tick("div0");
`ifdef ID_EX_DIV_ZERO_GUARD_EN
        chk("div0.op_lit", 32'(out_alu_control), 32'hF);
        chk("div0.flag_lit", 32'(out_div_zero), 32'd1);
`else
        chk("div0.op_lit", 32'(out_alu_control), 32'h3);
        chk("div0.flag_lit", 32'(out_div_zero), 32'd0);
`endif
        in_rt_data = 4;
        tick("div4");
        chk("div4.op_lit", 32'(out_alu_control), 32'h3);
        chk("div4.flag_lit", 32'(out_div_zero), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            random_inputs();
            tick("rand");
        end

        // Asynchronous reset with a held beat; no capture while reset is low
        quiet_inputs();
        in_valid = 1; in_rs_data = 32'hDEAD; in_reg_write = 1; in_alu_control = 4'h7;
        tick("ar_load");
        out_ready = 0;
        #2;
        rst_n = 0;
        #1;
        chk("async.valid", 32'(out_valid), 32'd0);
        chk("async.reg_write", 32'(out_reg_write), 32'd0);
        chk("async.x", out_x, 32'd0);
        chk("async.op", 32'(out_alu_control), 32'd0);
        model_reset();
        out_ready = 1;
        @(posedge clk); #1;
        chk("async.hold_low", 32'(out_valid), 32'd0);
        rst_n = 1;
        tick("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
